// File: rtl/ysyx_22050133_lsu_if.sv
// Memory-side bus of the load/store unit: a valid/ready request channel and a
// valid-only response channel carrying aligned 64-bit doublewords.
interface ysyx_22050133_lsu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_22050133_lsu.sv
// Load/store unit: one aligned doubleword transaction per instruction, with
// byte-lane placement for stores and sign/zero extension for loads.
module ysyx_22050133_lsu (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        is_load,
  input  logic                        is_store,
  input  logic [7:0]                  st_size,
  input  logic [4:0]                  ld_type,
  input  logic [63:0]                 addr,
  input  logic [63:0]                 wdata,
  input  logic [4:0]                  rd,
  ysyx_22050133_lsu_if.master         bus,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [63:0]                 out_data,
  output logic [4:0]                  out_rd,
  output logic                        out_wen,
  output logic                        out_misalign
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, wdata_q, out_data_q;
  logic [7:0]  wmask_q;
  logic        wen_q, load_q, misalign_q, out_wen_q;
  logic [4:0]  rd_q, ld_type_q;
  logic [2:0]  off_q;

  // Access size of the offered instruction: 0 byte, 1 half, 2 word, 3 dword.
  logic [1:0]  size;
  logic [7:0]  base_mask;
  logic        misalign;
  logic [63:0] shifted;
  logic [63:0] ext_data;

  // Decode size, misalignment and store mask base from the offered instruction.
  always_comb begin
    size      = 2'd3;
    base_mask = 8'h00;
    if (is_load) begin
      case (ld_type)
        5'd1, 5'd4: size = 2'd0;
        5'd2, 5'd5: size = 2'd1;
        5'd3, 5'd6: size = 2'd2;
        default:    size = 2'd3;
      endcase
    end else begin
      // Unknown store sizes still issue a request, but write no bytes.
      case (st_size)
        8'd1:    begin size = 2'd0; base_mask = 8'h01; end
        8'd2:    begin size = 2'd1; base_mask = 8'h03; end
        8'd3:    begin size = 2'd2; base_mask = 8'h0F; end
        8'd4:    begin size = 2'd3; base_mask = 8'hFF; end
        default: begin size = 2'd0; base_mask = 8'h00; end
      endcase
    end
    case (size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = addr[0];
      2'd2:    misalign = |addr[1:0];
      default: misalign = |addr[2:0];
    endcase
  end

  // Extract and extend the addressed lane of the returned doubleword.
  always_comb begin
    shifted = bus.mem_rdata >> {off_q, 3'b000};
    case (ld_type_q)
      5'd1:    ext_data = {{56{shifted[7]}}, shifted[7:0]};
      5'd2:    ext_data = {{48{shifted[15]}}, shifted[15:0]};
      5'd3:    ext_data = {{32{shifted[31]}}, shifted[31:0]};
      5'd4:    ext_data = {56'd0, shifted[7:0]};
      5'd5:    ext_data = {48'd0, shifted[15:0]};
      5'd6:    ext_data = {32'd0, shifted[31:0]};
      default: ext_data = shifted;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = misalign ? StDone : StReq;
      StReq:  if (bus.mem_req_ready) state_d = StWait;
      StWait: if (bus.mem_rsp_valid) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Latch the instruction on accept and the result on response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      wen_q      <= 1'b0;
      load_q     <= 1'b0;
      misalign_q <= 1'b0;
      rd_q       <= '0;
      ld_type_q  <= '0;
      off_q      <= '0;
      out_data_q <= '0;
      out_wen_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            addr_q     <= {addr[63:3], 3'b000};
            wdata_q    <= wdata << {addr[2:0], 3'b000};
            wmask_q    <= is_load ? 8'h00 : (base_mask << addr[2:0]);
            wen_q      <= ~is_load;
            load_q     <= is_load;
            misalign_q <= misalign;
            rd_q       <= rd;
            ld_type_q  <= ld_type;
            off_q      <= addr[2:0];
            out_data_q <= '0;
            out_wen_q  <= 1'b0;
          end
        end
        StWait: begin
          if (bus.mem_rsp_valid) begin
            out_data_q <= load_q ? ext_data : 64'd0;
            out_wen_q  <= load_q && (rd_q != 5'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready          = (state_q == StIdle);
  assign bus.mem_req_valid = (state_q == StReq);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign out_valid         = (state_q == StDone);
  assign out_data          = out_data_q;
  assign out_rd            = rd_q;
  assign out_wen           = out_wen_q;
  assign out_misalign      = misalign_q;

endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// Directed bench for the load/store unit: a vector table driven through a small
// memory responder with configurable stalls, plus a reset-during-WAIT sequence.
module tb_ysyx_22050133_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, is_load, is_store;
  logic [7:0]  st_size;
  logic [4:0]  ld_type, rd, out_rd;
  logic [63:0] addr, wdata, out_data;
  logic        out_valid, out_ready, out_wen, out_misalign;

  ysyx_22050133_lsu_if bus ();

  ysyx_22050133_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .is_load      (is_load),
    .is_store     (is_store),
    .st_size      (st_size),
    .ld_type      (ld_type),
    .addr         (addr),
    .wdata        (wdata),
    .rd           (rd),
    .bus          (bus),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .out_wen      (out_wen),
    .out_misalign (out_misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [7:0]  st_size;
    logic [4:0]  ld_type;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    int          req_stall;
    int          out_stall;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_mask;
    logic        e_wen;
    logic [63:0] e_data;
    logic        e_owen;
    logic        e_mis;
    int          e_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic run(input vec_t v, input int idx);
    int  req_cnt;
    int  done_cnt;
    bit  waiting;
    bit  got;
    string p;
    p = $sformatf("v%0d", idx);
    req_cnt = 0;
    done_cnt = 0;
    waiting = 1'b0;
    got = 1'b0;
    @(negedge clk);
    chk({p, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    is_load  = v.ld;
    is_store = v.st;
    st_size  = v.st_size;
    ld_type  = v.ld_type;
    addr     = v.addr;
    wdata    = v.wdata;
    rd       = v.rd;
    bus.mem_rdata = v.rdata;
    @(posedge clk);
    #1;
    // Scramble inputs so anything not latched at accept shows up.
    in_valid = 1'b0;
    addr     = ~v.addr;
    wdata    = ~v.wdata;
    rd       = ~v.rd;
    ld_type  = ~v.ld_type;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      if (waiting) begin
        bus.mem_rsp_valid = 1'b1;
        waiting = 1'b0;
      end
      if (bus.mem_req_valid) begin
        chk({p, ".mem_addr"},  bus.mem_addr, v.e_addr);
        chk({p, ".mem_wdata"}, bus.mem_wdata, v.e_wdata);
        chk({p, ".mem_wmask"}, 64'(bus.mem_wmask), 64'(v.e_mask));
        chk({p, ".mem_wen"},   64'(bus.mem_wen), 64'(v.e_wen));
        req_cnt++;
        if (req_cnt > v.req_stall) begin
          bus.mem_req_ready = 1'b1;
          waiting = 1'b1;
        end
      end
      if (out_valid) begin
        if (done_cnt == 0) chk({p, ".latency"}, 64'(cyc), 64'(v.e_lat));
        chk({p, ".out_data"},     out_data, v.e_data);
        chk({p, ".out_wen"},      64'(out_wen), 64'(v.e_owen));
        chk({p, ".out_rd"},       64'(out_rd), 64'(v.rd));
        chk({p, ".out_misalign"}, 64'(out_misalign), 64'(v.e_mis));
        chk({p, ".in_ready_busy"}, 64'(in_ready), 64'd0);
        if (done_cnt >= v.out_stall) begin
          out_ready = 1'b1;
          got = 1'b1;
        end
        done_cnt++;
      end
    end
    if (!got) begin
      failures++;
      checks++;
      $display("FAIL %s.timeout: out_valid never seen within 40 cycles", p);
    end
    chk({p, ".req_cycles"}, 64'(req_cnt), v.e_mis ? 64'd0 : 64'(v.req_stall + 1));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
  endtask

  initial begin
    // ld st size type addr wdata rd rdata rs os | e_addr e_wdata mask wen data owen mis lat
    vecs[0]  = '{1'b0, 1'b1, 8'd4, 5'd0, 64'h8000_0010, 64'h1122_3344_5566_7788, 5'd5, 64'd0, 0, 0,
                 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, 64'd0, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b0, 1'b1, 8'd1, 5'd0, 64'h8000_0003, 64'hAB, 5'd6, 64'd0, 0, 0,
                 64'h8000_0000, 64'hAB00_0000, 8'h08, 1'b1, 64'd0, 1'b0, 1'b0, 3};
    vecs[2]  = '{1'b1, 1'b0, 8'd0, 5'd1, 64'h8000_0005, 64'd0, 5'd7, 64'h0000_80FF_0000_0000, 0, 0,
                 64'h8000_0000, 64'd0, 8'h00, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 3};
    vecs[3]  = '{1'b1, 1'b0, 8'd0, 5'd4, 64'h8000_0005, 64'd0, 5'd7, 64'h0000_80FF_0000_0000, 0, 0,
                 64'h8000_0000, 64'd0, 8'h00, 1'b0, 64'h80, 1'b1, 1'b0, 3};
    vecs[4]  = '{1'b1, 1'b0, 8'd0, 5'd3, 64'h8000_0004, 64'd0, 5'd0, 64'h8000_0001_0000_0000, 0, 0,
                 64'h8000_0000, 64'd0, 8'h00, 1'b0, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b0, 3};
    vecs[5]  = '{1'b1, 1'b0, 8'd0, 5'd2, 64'h8000_0001, 64'd0, 5'd3, 64'hDEAD, 0, 0,
                 64'd0, 64'd0, 8'h00, 1'b0, 64'd0, 1'b0, 1'b1, 1};
    vecs[6]  = '{1'b1, 1'b0, 8'd0, 5'd0, 64'h8000_0008, 64'd0, 5'd10, 64'h0123_4567_89AB_CDEF, 4, 3,
                 64'h8000_0008, 64'd0, 8'h00, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 7};
    vecs[7]  = '{1'b0, 1'b1, 8'd2, 5'd0, 64'h8000_0006, 64'hBEEF, 5'd1, 64'd0, 1, 0,
                 64'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0, 1'b1, 64'd0, 1'b0, 1'b0, 4};
    vecs[8]  = '{1'b1, 1'b0, 8'd0, 5'd2, 64'h8000_0002, 64'd0, 5'd12, 64'h0000_0000_F00D_0000, 0, 1,
                 64'h8000_0000, 64'd0, 8'h00, 1'b0, 64'hFFFF_FFFF_FFFF_F00D, 1'b1, 1'b0, 3};
    vecs[9]  = '{1'b0, 1'b1, 8'd3, 5'd0, 64'h8000_0002, 64'h1234, 5'd4, 64'd0, 0, 0,
                 64'd0, 64'd0, 8'h00, 1'b0, 64'd0, 1'b0, 1'b1, 1};
    vecs[10] = '{1'b1, 1'b1, 8'd4, 5'd6, 64'h8000_0018, 64'hFFFF, 5'd9, 64'h0000_0000_8000_0001, 0, 0,
                 64'h8000_0018, 64'hFFFF, 8'h00, 1'b0, 64'h8000_0001, 1'b1, 1'b0, 3};
    vecs[11] = '{1'b0, 1'b1, 8'd0, 5'd0, 64'h8000_0020, 64'h55, 5'd2, 64'd0, 0, 0,
                 64'h8000_0020, 64'h55, 8'h00, 1'b1, 64'd0, 1'b0, 1'b0, 3};

    rst = 1'b0;
    in_valid = 1'b0;
    is_load = 1'b0;
    is_store = 1'b0;
    st_size = '0;
    ld_type = '0;
    addr = '0;
    wdata = '0;
    rd = '0;
    out_ready = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata = '0;

    repeat (3) @(negedge clk);
    chk("rst.in_ready",      64'(in_ready), 64'd1);
    chk("rst.mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst.mem_wen",       64'(bus.mem_wen), 64'd0);
    chk("rst.mem_addr",      bus.mem_addr, 64'd0);
    chk("rst.mem_wdata",     bus.mem_wdata, 64'd0);
    chk("rst.mem_wmask",     64'(bus.mem_wmask), 64'd0);
    chk("rst.out_valid",     64'(out_valid), 64'd0);
    chk("rst.out_data",      out_data, 64'd0);
    chk("rst.out_rd",        64'(out_rd), 64'd0);
    chk("rst.out_wen",       64'(out_wen), 64'd0);
    chk("rst.out_misalign",  64'(out_misalign), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) run(vecs[i], i);

    // Reset asserted while waiting for the response drops the transaction at once.
    @(negedge clk);
    in_valid = 1'b1;
    is_load = 1'b1;
    is_store = 1'b0;
    ld_type = 5'd0;
    addr = 64'h8000_0040;
    rd = 5'd8;
    bus.mem_rdata = 64'hCAFE;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstw.req_valid", 64'(bus.mem_req_valid), 64'd1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("rstw.in_ready_wait", 64'(in_ready), 64'd0);
    chk("rstw.req_valid_wait", 64'(bus.mem_req_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("rstw.in_ready", 64'(in_ready), 64'd1);
    chk("rstw.out_valid", 64'(out_valid), 64'd0);
    chk("rstw.mem_addr", bus.mem_addr, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    chk("late.out_valid", 64'(out_valid), 64'd0);
    chk("late.in_ready", 64'(in_ready), 64'd1);
    chk("late.out_data", out_data, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
